// File: rtl/forest_feed_vote.sv
// Feeds a 51-bit feature vector, assembled from a 7-byte frame, to NUM_TREES tree
// classifiers and majority-votes their 1-bit outputs into a handshaked result.
module forest_feed_vote #(
   parameter int NUM_TREES = 3,
   parameter int EVAL_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           s_data,
   input  logic                 s_valid,
   input  logic                 s_last,
   output logic                 s_ready,
   output logic [50:0]          feat,
   input  logic [NUM_TREES-1:0] tree_o,
   output logic                 m_class,
   output logic [3:0]           m_votes,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 err
);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      EVAL = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t      r_state;
   logic [2:0]  r_byte_cnt;
   logic [3:0]  r_wait_cnt;
   logic [50:0] r_feat;
   logic        r_class;
   logic [3:0]  r_votes;
   logic        r_valid;
   logic        r_err;
   logic [3:0]  w_votes;
   logic        w_class;

   function automatic logic [3:0] f_popcount(input logic [NUM_TREES-1:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int k = 0; k < NUM_TREES; k++) begin
         c = c + {3'd0, v[k]};
      end
      return c;
   endfunction

   // Strict majority: a tie on an even tree count resolves to class 0.
   assign w_votes = f_popcount(tree_o);
   assign w_class = ({1'b0, w_votes} << 1) > 5'(NUM_TREES);

   // Frame assembly, evaluation wait and result hold in one state machine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= LOAD;
         r_byte_cnt <= 3'd0;
         r_wait_cnt <= 4'd0;
         r_feat     <= 51'd0;
         r_class    <= 1'b0;
         r_votes    <= 4'd0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            LOAD: begin
               if (s_valid) begin
                  if (r_byte_cnt == 3'd6) begin
                     r_feat[50:48] <= s_data[2:0];
                     r_byte_cnt    <= 3'd0;
                     if (s_last) begin
                        r_state    <= EVAL;
                        r_wait_cnt <= 4'd0;
                     end else begin
                        r_err <= 1'b1;
                     end
                  end else begin
                     for (int k = 0; k < 6; k++) begin
                        if (r_byte_cnt == 3'(k)) begin
                           r_feat[8*k +: 8] <= s_data;
                        end
                     end
                     if (s_last) begin
                        r_err      <= 1'b1;
                        r_byte_cnt <= 3'd0;
                     end else begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                     end
                  end
               end
            end
            EVAL: begin
               if (r_wait_cnt == 4'(EVAL_LAT - 1)) begin
                  r_votes    <= w_votes;
                  r_class    <= w_class;
                  r_valid    <= 1'b1;
                  r_wait_cnt <= 4'd0;
                  r_state    <= OUT;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 4'd1;
               end
            end
            OUT: begin
               if (m_ready) begin
                  r_valid <= 1'b0;
                  r_state <= LOAD;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= LOAD;
            end
         endcase
      end
   end

   assign s_ready = (r_state == LOAD);
   assign feat    = r_feat;
   assign m_class = r_class;
   assign m_votes = r_votes;
   assign m_valid = r_valid;
   assign err     = r_err;

endmodule

// File: tb/tb_forest_feed_vote.sv
// Directed bench for forest_feed_vote: a default 3-tree instance plus a 4-tree
// instance sharing the same byte stream, checked against hand-computed values.
module tb_forest_feed_vote;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        m_ready;
   logic [2:0]  tree3;
   logic [3:0]  tree4;
   logic        s_ready3, s_ready4;
   logic [50:0] feat3, feat4;
   logic        class3, class4;
   logic [3:0]  votes3, votes4;
   logic        valid3, valid4;
   logic        err3, err4;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [55:0] FRAME_A = 56'hFF06_0504_0302_01;
   localparam logic [50:0] FEAT_A  = 51'h7_0605_0403_0201;
   localparam logic [55:0] FRAME_B = 56'h1615_1413_1211_10;
   localparam logic [50:0] FEAT_B  = 51'h6_1514_1312_1110;

   forest_feed_vote dut3 (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready3), .feat(feat3), .tree_o(tree3), .m_class(class3),
      .m_votes(votes3), .m_valid(valid3), .m_ready(m_ready), .err(err3)
   );

   forest_feed_vote #(.NUM_TREES(4), .EVAL_LAT(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready4), .feat(feat4), .tree_o(tree4), .m_class(class4),
      .m_votes(votes4), .m_valid(valid4), .m_ready(m_ready), .err(err4)
   );

   always #5 clk = ~clk;

   // Drives n bytes of a frame, one per cycle, raising s_last on byte last_idx.
   task automatic send_frame(input logic [55:0] bytes, input int n, input int last_idx);
      for (int i = 0; i < n; i++) begin
         s_data  = bytes[8*i +: 8];
         s_last  = (i == last_idx);
         s_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({feat3, class3, votes3, valid3, err3} !== 57'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got feat=%h class=%b votes=%0d valid=%b err=%b, want all 0",
                  feat3, class3, votes3, valid3, err3);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (s_ready3 !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got s_ready=%b, want 1", s_ready3);
      end
   endtask

   task automatic test_basic();
      tree3 = 3'b011;
      tree4 = 4'b0101;
      m_ready = 1'b1;
      send_frame(FRAME_A, 7, 6);
      n_vec++;
      if (feat3 !== FEAT_A || feat4 !== FEAT_A) begin
         n_err++;
         $display("FAIL basic_feat: got %h / %h, want %h", feat3, feat4, FEAT_A);
      end
      n_vec++;
      if (valid3 !== 1'b0 || s_ready3 !== 1'b0) begin
         n_err++;
         $display("FAIL basic_t1: got m_valid=%b s_ready=%b, want 0 0", valid3, s_ready3);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (valid3 !== 1'b1 || votes3 !== 4'd2 || class3 !== 1'b1) begin
         n_err++;
         $display("FAIL basic_result: got valid=%b votes=%0d class=%b, want 1 2 1",
                  valid3, votes3, class3);
      end
      n_vec++;
      if (valid4 !== 1'b1 || votes4 !== 4'd2 || class4 !== 1'b0) begin
         n_err++;
         $display("FAIL tie_result: got valid=%b votes=%0d class=%b, want 1 2 0",
                  valid4, votes4, class4);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (valid3 !== 1'b0 || s_ready3 !== 1'b1) begin
         n_err++;
         $display("FAIL basic_handshake: got valid=%b s_ready=%b, want 0 1", valid3, s_ready3);
      end
   endtask

   task automatic test_backpressure();
      tree3 = 3'b100;
      m_ready = 1'b0;
      send_frame(FRAME_A, 7, 6);
      @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
         n_vec++;
         if (valid3 !== 1'b1 || votes3 !== 4'd1 || class3 !== 1'b0 || s_ready3 !== 1'b0) begin
            n_err++;
            $display("FAIL hold_cycle%0d: got valid=%b votes=%0d class=%b s_ready=%b, want 1 1 0 0",
                     c, valid3, votes3, class3, s_ready3);
         end
         @(posedge clk);
         #1;
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (valid3 !== 1'b0 || s_ready3 !== 1'b1) begin
         n_err++;
         $display("FAIL hold_release: got valid=%b s_ready=%b, want 0 1", valid3, s_ready3);
      end
   endtask

   task automatic test_back_to_back();
      tree3 = 3'b111;
      tree4 = 4'b1101;
      send_frame(FRAME_B, 7, 6);
      @(posedge clk);
      #1;
      n_vec++;
      if (valid3 !== 1'b1 || votes3 !== 4'd3 || class3 !== 1'b1 || feat3 !== FEAT_B) begin
         n_err++;
         $display("FAIL b2b_result: got valid=%b votes=%0d class=%b feat=%h, want 1 3 1 %h",
                  valid3, votes3, class3, feat3, FEAT_B);
      end
      n_vec++;
      if (votes4 !== 4'd3 || class4 !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_four: got votes=%0d class=%b, want 3 1", votes4, class4);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_early_last();
      int seen_valid;
      tree3 = 3'b011;
      send_frame(FRAME_B, 4, 3);
      n_vec++;
      if (err3 !== 1'b1 || s_ready3 !== 1'b1 || valid3 !== 1'b0) begin
         n_err++;
         $display("FAIL early_err: got err=%b s_ready=%b valid=%b, want 1 1 0", err3, s_ready3, valid3);
      end
      seen_valid = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         if (valid3 !== 1'b0 || err3 !== 1'b0) seen_valid++;
      end
      n_vec++;
      if (seen_valid != 0) begin
         n_err++;
         $display("FAIL early_quiet: got %0d cycles with valid/err high, want 0", seen_valid);
      end
      send_frame(FRAME_A, 7, 6);
      @(posedge clk);
      #1;
      n_vec++;
      if (valid3 !== 1'b1 || votes3 !== 4'd2 || feat3 !== FEAT_A) begin
         n_err++;
         $display("FAIL early_recover: got valid=%b votes=%0d feat=%h, want 1 2 %h",
                  valid3, votes3, feat3, FEAT_A);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_missing_last();
      send_frame(FRAME_B, 7, 7);
      n_vec++;
      if (err3 !== 1'b1 || s_ready3 !== 1'b1 || valid3 !== 1'b0) begin
         n_err++;
         $display("FAIL nolast_err: got err=%b s_ready=%b valid=%b, want 1 1 0", err3, s_ready3, valid3);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (err3 !== 1'b0 || valid3 !== 1'b0) begin
         n_err++;
         $display("FAIL nolast_pulse: got err=%b valid=%b, want 0 0", err3, valid3);
      end
      tree3 = 3'b001;
      send_frame(FRAME_A, 7, 6);
      @(posedge clk);
      #1;
      n_vec++;
      if (valid3 !== 1'b1 || votes3 !== 4'd1 || class3 !== 1'b0 || feat3 !== FEAT_A) begin
         n_err++;
         $display("FAIL nolast_recover: got valid=%b votes=%0d class=%b feat=%h, want 1 1 0 %h",
                  valid3, votes3, class3, feat3, FEAT_A);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_eval();
      int seen_valid;
      tree3 = 3'b111;
      send_frame(FRAME_B, 7, 6);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({feat3, class3, votes3, valid3, err3} !== 57'd0) begin
         n_err++;
         $display("FAIL eval_reset: got feat=%h class=%b votes=%0d valid=%b err=%b, want all 0",
                  feat3, class3, votes3, valid3, err3);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      seen_valid = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         if (valid3 !== 1'b0 || err3 !== 1'b0) seen_valid++;
      end
      n_vec++;
      if (seen_valid != 0 || s_ready3 !== 1'b1) begin
         n_err++;
         $display("FAIL eval_release: got %0d busy cycles, s_ready=%b, want 0 and 1", seen_valid, s_ready3);
      end
   endtask

   initial begin
      s_data  = 8'h00;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      tree3   = 3'b000;
      tree4   = 4'b0000;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_early_last();
      test_missing_last();
      test_reset_eval();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/forest_feed_vote.md
FOREST_FEED_VOTE -- requirements
Module: forest_feed_vote

Interface
REQ-001 Parameter NUM_TREES, default 3, number of parallel tree classifiers fed and voted (1..15).
REQ-002 Parameter EVAL_LAT, default 1, cycles from feat update to tree_o sampling (1..15).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s_data  input  8  feature byte stream.
REQ-006 s_valid  input  1  s_data/s_last valid.
REQ-007 s_last  input  1  marks final byte of a frame.
REQ-008 s_ready  output  1  block accepts a byte this cycle.
REQ-009 feat  output  51  feature vector driven to every tree's i[50:0].
REQ-010 tree_o  input  NUM_TREES  bit k = 1-bit output o of tree k.
REQ-011 m_class  output  1  majority class result.
REQ-012 m_votes  output  4  count of trees voting 1.
REQ-013 m_valid  output  1  result valid.
REQ-014 m_ready  input  1  downstream accepts result.
REQ-015 err  output  1  one-cycle pulse on framing error.

Function
REQ-016 Byte transfer SHALL occur on a cycle with s_valid=1 and s_ready=1.
REQ-017 A frame SHALL be exactly 7 bytes; byte k (0..5) SHALL load feat[8k+7:8k]; byte 6 bits [2:0] SHALL load feat[50:48], bits [7:3] ignored.
REQ-018 FSM states SHALL be LOAD, EVAL, OUT; reset state LOAD.
REQ-019 LOAD: s_ready=1, m_valid=0; byte counter 0..6 increments per transfer.
REQ-020 LOAD, transfer of byte 6 with s_last=1: feat fully updated, counter to 0, next state EVAL.
REQ-021 LOAD, transfer with s_last=1 on byte 0..5: err=1 next cycle, counter to 0, frame discarded, stay LOAD, no result produced.
REQ-022 LOAD, transfer of byte 6 with s_last=0: err=1 next cycle, counter to 0, frame discarded, stay LOAD.
REQ-023 feat SHALL be written byte-by-byte during LOAD and held constant in EVAL and OUT; discarded frames may leave partial bytes in feat.
REQ-024 EVAL: s_ready=0; wait counter counts EVAL_LAT cycles; on the EVAL_LAT-th EVAL cycle tree_o sampled, m_votes = popcount(tree_o), next state OUT.
REQ-025 m_class SHALL be 1 iff 2*m_votes > NUM_TREES; ties (even NUM_TREES) give 0.
REQ-026 OUT: m_valid=1, s_ready=0, m_class/m_votes stable until m_valid&m_ready; then next state LOAD.
REQ-027 Latency: last byte accepted at cycle t -> m_valid=1 at cycle t+EVAL_LAT+1 (EVAL_LAT=1: t+2).
REQ-028 Back-to-back frames: first byte of next frame accepted earliest the cycle after the m_valid&m_ready handshake.
REQ-029 m_votes SHALL be zero-extended to 4 bits; bits of tree_o above NUM_TREES-1 do not exist.
REQ-030 err and m_valid never asserted in same cycle; err never asserted outside LOAD→LOAD transition.

Reset
REQ-031 rst_n=0 SHALL immediately force: state LOAD, byte counter 0, wait counter 0, feat=0, m_class=0, m_votes=0, m_valid=0, err=0; s_ready=1 after release.
REQ-032 Reset mid-frame or in EVAL/OUT SHALL abandon the frame with no result or err output.
REQ-033 First transfer accepted on first rising edge with rst_n=1.

Verification
REQ-034 Frame bytes 0x01,0x02,0x03,0x04,0x05,0x06,0xFF (last on byte 6), tree_o=3'b011 -> feat=51'h7_0605_0403_0201, m_votes=2, m_class=1, m_valid at t+2.
REQ-035 Same frame, tree_o=3'b100, m_ready held 0 for 5 cycles -> m_valid, m_votes=1, m_class=0 stable 5 cycles; s_ready=0 throughout; LOAD after handshake.
REQ-036 s_last=1 on byte 3 -> err pulse 1 cycle, no m_valid; following good 7-byte frame processed normally from byte 0.
REQ-037 7 bytes with s_last=0 on byte 6 -> err pulse, no m_valid, counter back to 0.
REQ-038 NUM_TREES=4, tree_o=4'b0101 -> m_votes=2, m_class=0 (tie).
REQ-039 rst_n pulled low in EVAL -> all outputs 0 asynchronously, no result after release, s_ready=1.
